// File: rtl/types_pkg.sv
// Shared types for the fetch/data memory arbiter.
package types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

  localparam logic [3:0] BE_FULL_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared-memory port of the arbiter.
interface mem_arbiter_if;

  logic                 f_req;
  types_pkg::word_t     f_addr;
  logic                 f_gnt;
  logic                 f_rvalid;
  types_pkg::word_t     f_rdata;

  logic                 d_req;
  logic                 d_we;
  types_pkg::word_t     d_addr;
  types_pkg::word_t     d_wdata;
  logic [3:0]           d_be;
  logic                 d_gnt;
  logic                 d_rvalid;
  types_pkg::word_t     d_rdata;

  logic                 mem_req;
  logic                 mem_we;
  types_pkg::word_t     mem_addr;
  types_pkg::word_t     mem_wdata;
  logic [3:0]           mem_be;
  logic                 mem_ready;
  logic                 mem_rvalid;
  types_pkg::word_t     mem_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // Requesters plus memory model side
  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin select: on a tie the requester not served last wins.
module rr_pick2
  import types_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last,
  output arb_owner_t winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = OWNER_FETCH;
    if (req == 2'b11) begin
      winner = (last == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
    end else if (req[1]) begin
      winner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one memory port, one transaction at a time.
module mem_arbiter
  import types_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  arb_state_t r_state;
  arb_owner_t r_owner;
  arb_owner_t r_last;
  word_t      r_addr;
  word_t      r_wdata;
  logic [3:0] r_be;
  logic       r_we;
  logic       r_f_rvalid;
  logic       r_d_rvalid;
  word_t      r_f_rdata;
  word_t      r_d_rdata;

  arb_owner_t w_win;
  logic       w_valid;
  logic       w_accept;

  rr_pick2 u_pick (
    .req    ({bus.d_req, bus.f_req}),
    .last   (r_last),
    .winner (w_win),
    .valid  (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OWNER_FETCH;
      r_last     <= OWNER_FETCH;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_state <= REQ;
            if (w_win == OWNER_DATA) begin
              r_addr  <= bus.d_addr;
              r_we    <= bus.d_we;
              r_wdata <= bus.d_wdata;
              r_be    <= bus.d_be;
            end else begin
              r_addr  <= bus.f_addr;
              r_we    <= 1'b0;
              r_be    <= BE_FULL_WORD;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            r_state <= r_we ? IDLE : RESP;
          end
        end
        RESP: begin
          // Data is registered so rvalid lands one cycle after mem_rvalid, already in IDLE
          if (bus.mem_rvalid) begin
            r_state <= IDLE;
            if (r_owner == OWNER_DATA) begin
              r_d_rdata  <= bus.mem_rdata;
              r_d_rvalid <= 1'b1;
            end else begin
              r_f_rdata  <= bus.mem_rdata;
              r_f_rvalid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_accept      = (r_state == REQ) && bus.mem_ready;

  assign bus.f_gnt     = w_accept && (r_owner == OWNER_FETCH);
  assign bus.d_gnt     = w_accept && (r_owner == OWNER_DATA);
  assign bus.f_rvalid  = r_f_rvalid;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.f_rdata   = r_f_rdata;
  assign bus.d_rdata   = r_d_rdata;

  assign bus.mem_req   = (r_state == REQ);
  assign bus.mem_we    = (r_state == REQ) && r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;

  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, tie alternation, stray strobes, reset.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  logic busy;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.f_req = 1'b0;  bus.f_addr = '0;
    bus.d_req = 1'b0;  bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) next_cycle();
    reset = 1'b0;

    // Reset values
    at_sample();
    check("rst_busy",    busy,          0);
    check("rst_mem_req", bus.mem_req,   0);
    check("rst_mem_we",  bus.mem_we,    0);
    check("rst_f_rdata", bus.f_rdata,   0);
    check("rst_mem_be",  bus.mem_be,    0);
    check("rst_mem_adr", bus.mem_addr,  0);

    // Fetch-only read
    bus.f_req = 1'b1; bus.f_addr = 32'h10;
    at_sample();
    check("f0_gnt", bus.f_gnt, 0);
    next_cycle();
    bus.mem_ready = 1'b1;
    at_sample();
    check("f1_mem_req", bus.mem_req,  1);
    check("f1_addr",    bus.mem_addr, 32'h10);
    check("f1_be",      bus.mem_be,   4'hF);
    check("f1_we",      bus.mem_we,   0);
    check("f1_f_gnt",   bus.f_gnt,    1);
    check("f1_d_gnt",   bus.d_gnt,    0);
    next_cycle();
    bus.f_req = 1'b0; bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    at_sample();
    check("f2_gnt",    bus.f_gnt,    0);
    check("f2_rvalid", bus.f_rvalid, 0);
    check("f2_busy",   busy,         1);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    at_sample();
    check("f3_rvalid",   bus.f_rvalid, 1);
    check("f3_rdata",    bus.f_rdata,  32'hDEADBEEF);
    check("f3_d_rvalid", bus.d_rvalid, 0);
    check("f3_busy",     busy,         0);
    next_cycle();
    at_sample();
    check("f4_rvalid", bus.f_rvalid, 0);
    check("f4_rdata",  bus.f_rdata,  32'hDEADBEEF);

    // Tie rounds after a fresh reset: data, fetch, data, fetch
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      automatic logic exp_data = (r % 2 == 0);
      bus.f_req = 1'b1; bus.f_addr = 32'h100 + r;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200 + r;
      next_cycle();
      bus.mem_ready = 1'b1;
      at_sample();
      check("tie_d_gnt", bus.d_gnt, exp_data);
      check("tie_f_gnt", bus.f_gnt, !exp_data);
      check("tie_addr",  bus.mem_addr, exp_data ? 32'h200 + r : 32'h100 + r);
      next_cycle();
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0 + r;
      next_cycle();
      bus.mem_rvalid = 1'b0;
      at_sample();
      check("tie_d_rvalid", bus.d_rvalid, exp_data);
      check("tie_f_rvalid", bus.f_rvalid, !exp_data);
      if (exp_data) check("tie_d_rdata", bus.d_rdata, 32'hA0 + r);
      else          check("tie_f_rdata", bus.f_rdata, 32'hA0 + r);
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    next_cycle();
    at_sample();
    check("tie_end_busy", busy, 0);

    // Data write with three wait states
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20;
    bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      at_sample();
      check("wr_wait_req",   bus.mem_req,   1);
      check("wr_wait_we",    bus.mem_we,    1);
      check("wr_wait_addr",  bus.mem_addr,  32'h20);
      check("wr_wait_wdata", bus.mem_wdata, 32'h12345678);
      check("wr_wait_be",    bus.mem_be,    4'b0011);
      check("wr_wait_gnt",   bus.d_gnt,     0);
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    at_sample();
    check("wr_req",    bus.mem_req,  1);
    check("wr_gnt",    bus.d_gnt,    1);
    check("wr_rvalid", bus.d_rvalid, 0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    next_cycle();
    bus.mem_ready = 1'b0;
    at_sample();
    check("wr_after_busy",   busy,         0);
    check("wr_after_req",    bus.mem_req,  0);
    check("wr_after_gnt",    bus.d_gnt,    0);
    check("wr_after_rvalid", bus.d_rvalid, 0);
    next_cycle();
    at_sample();
    check("wr_after2_rvalid", bus.d_rvalid, 0);

    // Stray mem_rvalid in IDLE; rdata must hold
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    at_sample();
    check("stray_f_rvalid", bus.f_rvalid, 0);
    check("stray_d_rvalid", bus.d_rvalid, 0);
    check("stray_busy",     busy,         0);
    check("stray_f_rdata",  bus.f_rdata,  32'hA3);
    check("stray_d_rdata",  bus.d_rdata,  32'hA2);

    // Stray mem_ready while in RESP
    bus.f_req = 1'b1; bus.f_addr = 32'h30;
    next_cycle();
    bus.mem_ready = 1'b1;
    next_cycle();
    bus.f_req = 1'b0;
    at_sample();
    check("resp_ready_gnt",  bus.f_gnt,   0);
    check("resp_ready_busy", busy,        1);
    check("resp_ready_req",  bus.mem_req, 0);
    next_cycle();
    at_sample();
    check("resp_ready_busy2",  busy,         1);
    check("resp_ready_rvalid", bus.f_rvalid, 0);
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    at_sample();
    check("resp_rvalid", bus.f_rvalid, 1);
    check("resp_rdata",  bus.f_rdata,  32'h77);

    // Reset while in RESP, with a late mem_rvalid
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    next_cycle();
    bus.mem_ready = 1'b1;
    next_cycle();
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    at_sample();
    check("rr_busy",     busy,         0);
    check("rr_d_rvalid", bus.d_rvalid, 0);
    check("rr_d_gnt",    bus.d_gnt,    0);
    check("rr_mem_req",  bus.mem_req,  0);
    check("rr_d_rdata",  bus.d_rdata,  0);
    check("rr_f_rdata",  bus.f_rdata,  0);
    check("rr_mem_addr", bus.mem_addr, 0);
    check("rr_mem_be",   bus.mem_be,   0);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    at_sample();
    check("rr_late_rvalid", bus.d_rvalid, 0);
    check("rr_late_rdata",  bus.d_rdata,  0);
    check("rr_late_busy",   busy,         0);

    // Back-to-back fetch reads
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    next_cycle();
    bus.mem_ready = 1'b1;
    at_sample();
    check("b2b_gnt1",  bus.f_gnt,    1);
    check("b2b_addr1", bus.mem_addr, 32'h0);
    bus.f_addr = 32'h4;
    next_cycle();
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    at_sample();
    check("b2b_rvalid1", bus.f_rvalid, 1);
    check("b2b_rdata1",  bus.f_rdata,  32'h1111);
    check("b2b_idle",    busy,         0);
    next_cycle();
    bus.mem_ready = 1'b1;
    at_sample();
    check("b2b_busy2", busy,         1);
    check("b2b_addr2", bus.mem_addr, 32'h4);
    check("b2b_gnt2",  bus.f_gnt,    1);
    bus.f_req = 1'b0;
    next_cycle();
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h2222;
    at_sample();
    check("b2b_mid_rvalid", bus.f_rvalid, 0);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    at_sample();
    check("b2b_rvalid2", bus.f_rvalid, 1);
    check("b2b_rdata2",  bus.f_rdata,  32'h2222);
    check("b2b_d_quiet", bus.d_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), reset input 1 (synchronous, active-high).
REQ-002 f_req  input  1  instruction-fetch read request; held until f_gnt.
REQ-003 f_addr  input  word_t  fetch address.
REQ-004 f_gnt / f_rvalid  output  1 each  fetch accept pulse / read-data-valid pulse.
REQ-005 f_rdata  output  word_t  fetch read data.
REQ-006 d_req, d_we  input  1 each  data-stage request; write when d_we=1.
REQ-007 d_addr, d_wdata  input  word_t  data address / write data.
REQ-008 d_be  input  4  byte enables for writes.
REQ-009 d_gnt / d_rvalid  output  1 each  data accept pulse / read-data-valid pulse.
REQ-010 d_rdata  output  word_t  data read data.
REQ-011 mem_req, mem_we  output  1 each  shared-memory request / write strobe.
REQ-012 mem_addr, mem_wdata  output  word_t  shared-memory address / write data.
REQ-013 mem_be  output  4  shared-memory byte enables.
REQ-014 mem_ready  input  1  memory accepts the request this cycle.
REQ-015 mem_rvalid, mem_rdata  input  1, word_t  read response.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and RESP.
REQ-018 IDLE: when any request is sampled, the winner's addr/we/wdata/be/owner SHALL be latched, and the FSM SHALL enter REQ.
- Fetch requests latch we=0 and be=4'b1111.
REQ-019 Arbitration SHALL work as follows:
- A single requester wins.
- When both request, the owner not served last wins.
- last_served SHALL update at each latch.
REQ-020 REQ: mem_req=1, with mem_* driven only from latched registers.
- On mem_ready: the owner's gnt pulses for exactly that cycle.
- A write then returns to IDLE; a read goes to RESP.
REQ-021 RESP: on mem_rvalid, mem_rdata SHALL be registered into the owner's rdata, and the owner's rvalid SHALL pulse high for one cycle, in the cycle after mem_rvalid.
- The FSM returns to IDLE on the same edge.
REQ-022 Read latency with zero-wait memory SHALL be 3 cycles from req sample to rvalid (req@0, gnt@1, mem_rvalid@2, rvalid@3).
REQ-023 In the cycle rvalid is high, the FSM is in IDLE and SHALL accept a new request, giving back-to-back issue.
REQ-024 f_rdata/d_rdata SHALL hold their value until the next rvalid to the same owner.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 mem_ready outside REQ and mem_rvalid outside RESP SHALL be ignored.
REQ-027 A latched transaction SHALL run to completion even if the requester drops req; abort is not supported.
REQ-028 The non-owner's gnt/rvalid SHALL stay 0 throughout a transaction.
REQ-029 mem_req SHALL stay high in REQ until mem_ready, with unbounded wait states.

Reset
REQ-030 Reset SHALL apply the following values:
- State IDLE, last_served = FETCH (so data wins the first tie).
- All gnt/rvalid/mem_req/mem_we/busy = 0.
- rdata, mem_addr, mem_wdata = 0; mem_be = 0.
REQ-031 Reset asserted mid-transaction SHALL discard the outstanding transaction with no gnt/rvalid, and any late mem_rvalid SHALL be ignored.

Structure
REQ-032 types_pkg SHALL hold the following shared definitions:
- arb_state_t (IDLE, REQ, RESP).
- arb_owner_t (OWNER_FETCH=0, OWNER_DATA=1).
- word_t, reused from the package.
REQ-033 One sub-module, rr_pick2, SHALL be used: combinational two-way round-robin select taking req[1:0] and last and returning winner and valid; everything else stays in mem_arbiter.

Verification
REQ-034 Fetch-only read, f_addr=0x10, mem_ready=1, mem_rdata=0xDEADBEEF at cycle 2 -> f_gnt@1, f_rvalid@3, f_rdata=0xDEADBEEF, d_* silent.
REQ-035 Simultaneous f_req and d_req after reset -> data granted first, then fetch; alternation holds over 4 consecutive tie rounds.
REQ-036 Data write, d_addr=0x20, d_wdata=0x12345678, d_be=4'b0011, mem_ready low 3 cycles -> mem_req held 4 cycles with stable outputs, d_gnt one pulse, no d_rvalid, busy low the following cycle.
REQ-037 mem_rvalid during IDLE, plus a stray mem_ready during RESP -> no rvalid/gnt, state unchanged.
REQ-038 Reset asserted while in RESP -> the next cycle is IDLE with all outputs at reset values, and a subsequent mem_rvalid produces no rvalid.
REQ-039 Back-to-back fetch reads (0x0, 0x4) with zero-wait memory -> the second request is latched in the cycle f_rvalid is high, and its f_rvalid follows 3 cycles later.
